// File: rtl/jk_mode_register.sv
// rtl/jk_mode_register.sv - WIDTH-bit JK/load/modulo up-down register with terminal-count pulse
// Optional lap capture register (LAP/LapQ) enabled by defining JKREG_LAP_EN.
module jk_mode_register #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CP,
  input  logic             CLR,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
`ifdef JKREG_LAP_EN
  input  logic             LAP,
  output logic [WIDTH-1:0] LapQ,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] invQ,
  output logic             TC
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_UP   = 2'b10,
    MODE_DOWN = 2'b11
  } mode_e;

  // MODULUS may equal 2^WIDTH, so range checks use one extra bit.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] invq_q;
  logic             tc_q, tc_d;
  logic             out_of_range;

  assign out_of_range = ({1'b0, q_q} >= MOD_W);

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (EN) begin
      case (mode_e'(MODE))
        MODE_JK:   q_d = (J & ~q_q) | (~K & q_q);
        MODE_LOAD: q_d = J;
        MODE_UP: begin
          if (out_of_range) begin
            q_d = '0;
          end else if (q_q == MAX_V) begin
            q_d  = '0;
            tc_d = 1'b1;
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (out_of_range) begin
            q_d = MAX_V;
          end else if (q_q == '0) begin
            q_d  = MAX_V;
            tc_d = 1'b1;
          end else begin
            q_d = q_q - WIDTH'(1);
          end
        end
        default: q_d = q_q;
      endcase
    end
  end

  // invQ is registered from the next-state value so it never lags Q.
  always_ff @(posedge CP) begin
    if (CLR) begin
      q_q    <= '0;
      invq_q <= '1;
      tc_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      invq_q <= ~q_d;
      tc_q   <= tc_d;
    end
  end

`ifdef JKREG_LAP_EN
  logic [WIDTH-1:0] lap_q;

  always_ff @(posedge CP) begin
    if (CLR) begin
      lap_q <= '0;
    end else if (LAP) begin
      lap_q <= q_q;
    end
  end

  assign LapQ = lap_q;
`endif

  assign Q    = q_q;
  assign invQ = invq_q;
  assign TC   = tc_q;

endmodule

// File: tb/tb_jk_mode_register.sv
// tb/tb_jk_mode_register.sv - directed self-checking bench for jk_mode_register
module tb_jk_mode_register;

  localparam int W = 4;

  logic         CP;
  logic         CLR;
  logic         EN;
  logic [1:0]   MODE;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic [W-1:0] Q;
  logic [W-1:0] invQ;
  logic         TC;
`ifdef JKREG_LAP_EN
  logic         LAP;
  logic [W-1:0] LapQ;
`endif

  int checks = 0;
  int errors = 0;

  jk_mode_register #(.WIDTH(W), .MODULUS(10)) dut (
    .CP   (CP),
    .CLR  (CLR),
    .EN   (EN),
    .MODE (MODE),
    .J    (J),
    .K    (K),
`ifdef JKREG_LAP_EN
    .LAP  (LAP),
    .LapQ (LapQ),
`endif
    .Q    (Q),
    .invQ (invQ),
    .TC   (TC)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic tick;
    @(posedge CP);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    CLR = 1'b0; EN = 1'b1; MODE = 2'b01; J = v; K = '0;
    tick();
  endtask

  task automatic test_reset;
    load(4'd5);
    CLR = 1'b1; MODE = 2'b10; J = 4'hA; K = 4'h3;
    tick();
    tick();
    checks++;
    if ({Q, invQ, TC} !== {4'h0, 4'hF, 1'b0}) begin
      $display("FAIL reset Q=%h invQ=%h TC=%b expected Q=0 invQ=f TC=0", Q, invQ, TC);
      errors++;
    end
    CLR = 1'b0;
  endtask

  task automatic test_hold;
    load(4'd7);
    EN = 1'b0; MODE = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({Q, invQ, TC} !== {4'd7, 4'd8, 1'b0}) begin
        $display("FAIL hold[%0d] Q=%h invQ=%h TC=%b expected Q=7 invQ=8 TC=0", i, Q, invQ, TC);
        errors++;
      end
    end
    EN = 1'b1;
  endtask

  task automatic test_jk;
    logic [W-1:0] jv [3] = '{4'b1100, 4'b1111, 4'b0000};
    logic [W-1:0] kv [3] = '{4'b0110, 4'b1111, 4'b1111};
    logic [W-1:0] ev [3] = '{4'b1100, 4'b0011, 4'b0000};
    load(4'b1010);
    for (int i = 0; i < 3; i++) begin
      MODE = 2'b00; J = jv[i]; K = kv[i];
      tick();
      checks++;
      if ({Q, invQ, TC} !== {ev[i], ~ev[i], 1'b0}) begin
        $display("FAIL jk[%0d] Q=%b invQ=%b TC=%b expected Q=%b invQ=%b TC=0",
                 i, Q, invQ, TC, ev[i], ~ev[i]);
        errors++;
      end
    end
  endtask

  task automatic test_up_wrap;
    logic [W-1:0] e;
    load(4'd0);
    MODE = 2'b10;
    for (int i = 0; i < 20; i++) begin
      e = W'((i + 1) % 10);
      tick();
      checks++;
      if ({Q, invQ, TC} !== {e, ~e, (e == 4'd0)}) begin
        $display("FAIL up[%0d] Q=%0d invQ=%h TC=%b expected Q=%0d TC=%b",
                 i, Q, invQ, TC, e, (e == 4'd0));
        errors++;
      end
    end
  endtask

  task automatic test_down_oor;
    load(4'd0);
    MODE = 2'b11;
    tick();
    checks++;
    if ({Q, invQ, TC} !== {4'd9, 4'd6, 1'b1}) begin
      $display("FAIL down_wrap Q=%0d invQ=%h TC=%b expected Q=9 TC=1", Q, invQ, TC);
      errors++;
    end
    tick();
    checks++;
    if ({Q, TC} !== {4'd8, 1'b0}) begin
      $display("FAIL down_step Q=%0d TC=%b expected Q=8 TC=0", Q, TC);
      errors++;
    end
    load(4'd13);
    checks++;
    if ({Q, invQ, TC} !== {4'd13, 4'd2, 1'b0}) begin
      $display("FAIL load13 Q=%0d invQ=%h TC=%b expected Q=13 TC=0", Q, invQ, TC);
      errors++;
    end
    MODE = 2'b10;
    tick();
    checks++;
    if ({Q, invQ, TC} !== {4'd0, 4'hF, 1'b0}) begin
      $display("FAIL up_oor Q=%0d invQ=%h TC=%b expected Q=0 TC=0", Q, invQ, TC);
      errors++;
    end
    load(4'd13);
    MODE = 2'b11;
    tick();
    checks++;
    if ({Q, invQ, TC} !== {4'd9, 4'd6, 1'b0}) begin
      $display("FAIL down_oor Q=%0d invQ=%h TC=%b expected Q=9 TC=0", Q, invQ, TC);
      errors++;
    end
  endtask

  task automatic test_reset_mid;
    load(4'd9);
    MODE = 2'b10; CLR = 1'b1;
    tick();
    checks++;
    if ({Q, invQ, TC} !== {4'd0, 4'hF, 1'b0}) begin
      $display("FAIL reset_mid Q=%0d invQ=%h TC=%b expected Q=0 TC=0", Q, invQ, TC);
      errors++;
    end
    CLR = 1'b0;
    tick();
    checks++;
    if ({Q, TC} !== {4'd1, 1'b0}) begin
      $display("FAIL after_reset Q=%0d TC=%b expected Q=1 TC=0", Q, TC);
      errors++;
    end
  endtask

  task automatic test_back_to_back;
    load(4'd1);
    MODE = 2'b11;
    tick();
    MODE = 2'b10;
    tick();
    checks++;
    if ({Q, TC} !== {4'd1, 1'b0}) begin
      $display("FAIL mode_switch Q=%0d TC=%b expected Q=1 TC=0", Q, TC);
      errors++;
    end
    MODE = 2'b11;
    tick();
    tick();
    checks++;
    if ({Q, TC} !== {4'd9, 1'b1}) begin
      $display("FAIL switch_wrap Q=%0d TC=%b expected Q=9 TC=1", Q, TC);
      errors++;
    end
  endtask

`ifdef JKREG_LAP_EN
  task automatic test_lap;
    load(4'd6);
    MODE = 2'b10; LAP = 1'b1;
    tick();
    checks++;
    if ({LapQ, Q} !== {4'd6, 4'd7}) begin
      $display("FAIL lap_count LapQ=%0d Q=%0d expected LapQ=6 Q=7", LapQ, Q);
      errors++;
    end
    EN = 1'b0;
    tick();
    checks++;
    if ({LapQ, Q} !== {4'd7, 4'd7}) begin
      $display("FAIL lap_hold LapQ=%0d Q=%0d expected LapQ=7 Q=7", LapQ, Q);
      errors++;
    end
    LAP = 1'b0; EN = 1'b1; CLR = 1'b1;
    tick();
    checks++;
    if (LapQ !== 4'd0) begin
      $display("FAIL lap_clr LapQ=%0d expected 0", LapQ);
      errors++;
    end
    CLR = 1'b0;
  endtask
`endif

  initial begin
    CLR = 1'b1; EN = 1'b0; MODE = 2'b00; J = '0; K = '0;
`ifdef JKREG_LAP_EN
    LAP = 1'b0;
`endif
    tick();
    test_reset();
    test_hold();
    test_jk();
    test_up_wrap();
    test_down_oor();
    test_reset_mid();
    test_back_to_back();
`ifdef JKREG_LAP_EN
    test_lap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
